// File: rtl/sram_adapter_pkg.sv
// Shared types for the 1RW SRAM request adapter.
// Control encodings are {csb, web, oeb}, all active low.
package sram_adapter_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   typedef struct packed {
      logic csb;
      logic web;
      logic oeb;
   } sram_ctrl_t;

   localparam sram_ctrl_t CTRL_IDLE = 3'b111;
   localparam sram_ctrl_t CTRL_RD   = 3'b010;
   localparam sram_ctrl_t CTRL_WR   = 3'b001;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small circular response FIFO holding SRAM read data.
// Credit accounting lives in the parent; this block only stores.
module sram_resp_fifo #(
   parameter int DATA_W     = 32,
   parameter int RESP_DEPTH = 2
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              push,
   input  logic [DATA_W-1:0]                 push_data,
   input  logic                              pop,
   output logic [DATA_W-1:0]                 pop_data,
   output logic [$clog2(RESP_DEPTH+1)-1:0]   count,
   output logic                              full,
   output logic                              empty
);

   localparam int CNT_W = $clog2(RESP_DEPTH+1);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(RESP_DEPTH-1);

   logic [DATA_W-1:0] mem [RESP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(RESP_DEPTH));
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/sram1rw_req_adapter.sv
// Valid/ready front end for a single-port 1RW SRAM macro, with a
// post-reset zero-fill sweep and a credit-limited response FIFO.
module sram1rw_req_adapter
   import sram_adapter_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int RESP_DEPTH = 2,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   output logic              init_done,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              sram_ce,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_i,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic              sram_csb,
   input  logic [DATA_W-1:0] sram_o
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = $clog2(RESP_DEPTH+1);

   state_e            state;
   state_e            state_nx;
   sram_ctrl_t        ctrl;
   logic [ADDR_W-1:0] init_cnt;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] i_q;
   logic              rd_pend;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              hs;
   logic              rd_hs;
   logic [CNT_W:0]    used;

   assign sram_ce    = clock;
   assign resp_valid = !fifo_empty;
   assign pop        = resp_valid && resp_ready;

   // Outstanding reads = stored + one in the SRAM output register,
   // less whatever leaves this cycle.
   assign used = {1'b0, fifo_count} + (CNT_W+1)'(rd_pend)
               - (CNT_W+1)'(pop);

   assign req_ready = (state == ST_RUN) && init_done
                   && (used < (CNT_W+1)'(RESP_DEPTH));
   assign hs    = req_valid && req_ready;
   assign rd_hs = hs && !req_we;

   assign sram_csb = ctrl.csb;
   assign sram_web = ctrl.web;
   assign sram_oeb = ctrl.oeb;

   always_comb begin
      state_nx = state;
      ctrl     = CTRL_IDLE;
      sram_a   = a_q;
      sram_i   = i_q;
      unique case (state)
         ST_INIT: begin
            ctrl   = CTRL_WR;
            sram_a = init_cnt;
            sram_i = '0;
            if (init_cnt == ADDR_W'(DEPTH-1))
               state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (hs) begin
               ctrl   = req_we ? CTRL_WR : CTRL_RD;
               sram_a = req_addr;
               if (req_we)
                  sram_i = req_wdata;
            end
         end
         default: ;
      endcase
      // The chip must be deselected while reset is held.
      if (reset)
         ctrl = CTRL_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= INIT_EN ? ST_INIT : ST_RUN;
         init_done <= 1'b0;
         init_cnt  <= '0;
         a_q       <= '0;
         i_q       <= '0;
         rd_pend   <= 1'b0;
      end else begin
         state     <= state_nx;
         init_done <= (state_nx == ST_RUN);
         if (state == ST_INIT)
            init_cnt <= init_cnt + 1'b1;
         a_q     <= sram_a;
         i_q     <= sram_i;
         rd_pend <= rd_hs;
      end
   end

   sram_resp_fifo #(
      .DATA_W     (DATA_W),
      .RESP_DEPTH (RESP_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rd_pend),
      .push_data (sram_o),
      .pop       (pop),
      .pop_data  (resp_rdata),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   a_no_overflow: assert property (
      @(posedge clock) disable iff (reset)
      !(rd_pend && fifo_full && !pop)
   );

endmodule

// File: tb/tb_sram1rw_req_adapter.sv
// Randomized bench for sram1rw_req_adapter with an SRAM model and
// a queue-based reference of memory contents and outstanding reads.
module tb_sram1rw_req_adapter;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 64;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          init_done;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_rdata;
   logic          sram_ce;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_i;
   logic          sram_web;
   logic          sram_oeb;
   logic          sram_csb;
   logic [DW-1:0] sram_o;

   logic          reset2 = 1'b1;
   logic          u1_init_done;
   logic          u1_req_ready;
   logic          u1_resp_valid;
   logic [DW-1:0] u1_resp_rdata;
   logic          u1_sram_ce;
   logic [AW-1:0] u1_sram_a;
   logic [DW-1:0] u1_sram_i;
   logic          u1_sram_web;
   logic          u1_sram_oeb;
   logic          u1_sram_csb;

   always #5 clock = ~clock;

   sram1rw_req_adapter #(
      .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(2), .INIT_EN(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .init_done(init_done),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .sram_ce(sram_ce), .sram_a(sram_a),
      .sram_i(sram_i), .sram_web(sram_web), .sram_oeb(sram_oeb),
      .sram_csb(sram_csb), .sram_o(sram_o)
   );

   sram1rw_req_adapter #(
      .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(2), .INIT_EN(1'b0)
   ) dut_noinit (
      .clock(clock), .reset(reset2), .init_done(u1_init_done),
      .req_valid(1'b0), .req_ready(u1_req_ready),
      .req_we(1'b0), .req_addr('0), .req_wdata('0),
      .resp_valid(u1_resp_valid), .resp_ready(1'b1),
      .resp_rdata(u1_resp_rdata), .sram_ce(u1_sram_ce),
      .sram_a(u1_sram_a), .sram_i(u1_sram_i), .sram_web(u1_sram_web),
      .sram_oeb(u1_sram_oeb), .sram_csb(u1_sram_csb), .sram_o('0)
   );

   // SRAM macro model: random power-up contents, registered read port.
   logic [DW-1:0] sram_mem [DEPTH];
   initial begin
      for (int k = 0; k < DEPTH; k++) sram_mem[k] = $urandom;
      sram_o = $urandom;
   end
   always @(posedge sram_ce) begin
      if (!sram_csb) begin
         if (!sram_web) sram_mem[sram_a] <= sram_i;
         else if (!sram_oeb) sram_o <= sram_mem[sram_a];
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // Reference: memory image plus ordered list of outstanding reads,
   // each tagged with the cycle its data becomes visible.
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic [DW-1:0] ref_mem [DEPTH];
   exp_t          exp_q[$];
   int            cyc = 0;

   task automatic step(input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rr);
      logic exp_rv;
      logic exp_rdy;
      logic pop;
      logic hs;
      int   used;
      req_valid = v;
      req_we = we;
      req_addr = a;
      req_wdata = d;
      resp_ready = rr;
      #1;
      exp_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      pop = exp_rv && rr;
      if (pop) chk("resp_rdata", resp_rdata, exp_q[0].data);
      used = exp_q.size() - (pop ? 1 : 0);
      exp_rdy = (used < 2);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      hs = v && exp_rdy;
      chk("sram_csb", 32'(sram_csb), 32'(!hs));
      if (hs) begin
         chk("sram_a", 32'(sram_a), 32'(a));
         if (we) begin
            chk("sram_web_wr", 32'(sram_web), 32'd0);
            chk("sram_i", sram_i, d);
            ref_mem[a] = d;
         end else begin
            chk("sram_oeb_rd", 32'(sram_oeb), 32'd0);
            exp_q.push_back('{ref_mem[a], cyc + 2});
         end
      end
      if (pop) void'(exp_q.pop_front());
      @(negedge clock);
      cyc++;
   endtask

   // Called right at the negedge where reset was released.
   task automatic init_sweep();
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         chk("init_a", 32'(sram_a), 32'(k));
         chk("init_csb", 32'(sram_csb), 32'd0);
         chk("init_web", 32'(sram_web), 32'd0);
         chk("init_i", sram_i, '0);
         chk("init_ready", 32'(req_ready), 32'd0);
         chk("init_done_lo", 32'(init_done), 32'd0);
         @(negedge clock);
      end
      #1;
      chk("init_done_hi", 32'(init_done), 32'd1);
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_csb", 32'(sram_csb), 32'd1);
      chk("rst_web", 32'(sram_web), 32'd1);
      chk("rst_oeb", 32'(sram_oeb), 32'd1);
      chk("rst_a", 32'(sram_a), 32'd0);
      chk("rst_i", sram_i, '0);
      chk("noinit_rst_done", 32'(u1_init_done), 32'd0);
      chk("noinit_rst_ready", 32'(u1_req_ready), 32'd0);

      @(negedge clock);
      reset2 = 1'b0;
      @(negedge clock);
      #1;
      chk("noinit_done", 32'(u1_init_done), 32'd1);
      chk("noinit_ready", 32'(u1_req_ready), 32'd1);

      @(negedge clock);
      reset = 1'b0;
      init_sweep();

      step(1'b1, 1'b0, 6'h2A, '0, 1'b1);
      idle(3);
      step(1'b1, 1'b1, 6'h05, 32'hDEADBEEF, 1'b1);
      step(1'b1, 1'b0, 6'h05, '0, 1'b1);
      idle(3);

      for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 6'(k), '0, 1'b1);
      idle(3);

      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'(k), '0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 6'(k+8), '0, 1'b1);
      idle(3);

      for (int k = 0; k < 2000; k++)
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) != 0);
      idle(3);

      // Two reads with resp_ready low: one stored, one still in flight.
      step(1'b1, 1'b0, 6'h01, '0, 1'b0);
      step(1'b1, 1'b0, 6'h02, '0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_csb", 32'(sram_csb), 32'd1);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_done", 32'(init_done), 32'd0);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      init_sweep();
      idle(4);
      for (int k = 0; k < 300; k++)
         step($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)),
              6'($urandom), $urandom, $urandom_range(0, 1) != 0);
      idle(3);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
